// File: rtl/dmem_req_ctrl_pkg.sv
// Shared definitions for the data-memory request controller: bus sizes and
// commands, XLEN, the controller state enum and the latched request payload.
package dmem_req_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;

  typedef enum logic [1:0] {
    BYTE = 2'h0,
    HALF = 2'h1,
    WORD = 2'h2
  } MEM_SIZE;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [2:0] {
    DMEM_IDLE  = 3'h0,
    DMEM_ISSUE = 3'h1,
    DMEM_WAIT  = 3'h2,
    DMEM_DRAIN = 3'h3,
    DMEM_DONE  = 3'h4
  } DMEM_REQ_STATE;

  // Request as latched at acceptance
  typedef struct packed {
    logic            is_store;
    logic [1:0]      size;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } dmem_req_t;

  // HALF needs addr[0]==0, WORD needs addr[1:0]==0; BYTE is always aligned
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == HALF) && addr_lo[0]) || ((size == WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_req_ctrl_if.sv
// Handshake and Dmem bus bundle for dmem_req_ctrl.
//   request side : flush, req_valid/req_ready, req_is_store, req_size, req_addr, req_data
//   Dmem bus     : proc2Dmem_command/size/addr/data, Dmem2proc_response/data/tag
//   completion   : resp_valid, resp_is_store, resp_err, resp_data
// Modports: slave = the controller, master = the issuing pipeline plus memory.
interface dmem_req_ctrl_if;
  import dmem_req_ctrl_pkg::*;

  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic             req_is_store;
  logic [1:0]       req_size;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  req_data;

  logic [1:0]       proc2Dmem_command;
  logic [1:0]       proc2Dmem_size;
  logic [XLEN-1:0]  proc2Dmem_addr;
  logic [XLEN-1:0]  proc2Dmem_data;
  logic [TAG_W-1:0] Dmem2proc_response;
  logic [XLEN-1:0]  Dmem2proc_data;
  logic [TAG_W-1:0] Dmem2proc_tag;

  logic             resp_valid;
  logic             resp_is_store;
  logic             resp_err;
  logic [XLEN-1:0]  resp_data;

  modport slave (
    input  flush, req_valid, req_is_store, req_size, req_addr, req_data,
    input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
    output req_ready,
    output proc2Dmem_command, proc2Dmem_size, proc2Dmem_addr, proc2Dmem_data,
    output resp_valid, resp_is_store, resp_err, resp_data
  );

  modport master (
    output flush, req_valid, req_is_store, req_size, req_addr, req_data,
    output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
    input  req_ready,
    input  proc2Dmem_command, proc2Dmem_size, proc2Dmem_addr, proc2Dmem_data,
    input  resp_valid, resp_is_store, resp_err, resp_data
  );

endinterface

// File: rtl/dmem_req_ctrl.sv
// Sequential data-memory request controller between EX issue and the tagged
// Dmem bus. Accepts one load/store at a time, holds the bus command until the
// memory returns a nonzero tag, then waits for that tag's data (loads) and
// emits a one-cycle completion carrying the raw word, store flag or error.
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus            : dmem_req_ctrl_if.slave (request, Dmem bus, completion)
//   stat_loads, stat_stores, stat_stall_cycles : 32-bit counters, present
//                    only when DMEM_REQ_STATS_EN is defined
// Parameter MAX_WAIT: cycles spent waiting for a load tag before erroring.
module dmem_req_ctrl
  import dmem_req_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic           clock,
  input  logic           reset_n,
  dmem_req_ctrl_if.slave bus
`ifdef DMEM_REQ_STATS_EN
  ,
  output logic [31:0]    stat_loads,
  output logic [31:0]    stat_stores,
  output logic [31:0]    stat_stall_cycles
`endif
);

  localparam int unsigned      CNT_W     = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  DMEM_REQ_STATE    state_q, state_d;
  dmem_req_t        req_q, req_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [XLEN-1:0]  data_q, data_d;

  logic             tag_hit;
  logic             wait_expired;
  logic [CNT_W-1:0] cnt_inc;

  // Latched tag is never 0 while WAIT/DRAIN is active, so "no return" never matches
  assign tag_hit      = (bus.Dmem2proc_tag == tag_q);
  assign wait_expired = (cnt_q == WAIT_LAST);
  assign cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // State, request, tag, counter and result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DMEM_IDLE;
      req_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    data_d  = data_q;

    unique case (state_q)
      DMEM_IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          req_d.is_store = bus.req_is_store;
          req_d.size     = bus.req_size;
          req_d.addr     = bus.req_addr;
          req_d.data     = bus.req_data;
          data_d         = '0;
          if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = DMEM_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = DMEM_ISSUE;
          end
        end
      end

      DMEM_ISSUE: begin
        // A flushed cycle drives BUS_NONE, so any response is not an acceptance
        if (bus.flush) begin
          state_d = DMEM_IDLE;
        end else if (bus.Dmem2proc_response != '0) begin
          if (req_q.is_store) begin
            state_d = DMEM_DONE;
          end else begin
            tag_d   = bus.Dmem2proc_response;
            cnt_d   = '0;
            state_d = DMEM_WAIT;
          end
        end
      end

      DMEM_WAIT: begin
        if (tag_hit) begin
          data_d  = bus.Dmem2proc_data;
          state_d = bus.flush ? DMEM_IDLE : DMEM_DONE;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = bus.flush ? DMEM_IDLE : DMEM_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (bus.flush) begin
            state_d = DMEM_DRAIN;
          end
        end
      end

      // Squashed load: swallow its tag (or give up) without reporting
      DMEM_DRAIN: begin
        if (tag_hit || wait_expired) begin
          state_d = DMEM_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      DMEM_DONE: begin
        state_d = DMEM_IDLE;
      end

      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
  end

  // Outputs: handshake, bus command and completion follow state and flush directly
  always_comb begin
    bus.req_ready         = 1'b0;
    bus.proc2Dmem_command = BUS_NONE;
    bus.proc2Dmem_size    = req_q.size;
    bus.proc2Dmem_addr    = req_q.addr;
    bus.proc2Dmem_data    = req_q.data;
    bus.resp_valid        = 1'b0;
    bus.resp_is_store     = 1'b0;
    bus.resp_err          = 1'b0;
    bus.resp_data         = '0;

    if ((state_q == DMEM_IDLE) && !bus.flush) begin
      bus.req_ready = 1'b1;
    end

    if ((state_q == DMEM_ISSUE) && !bus.flush) begin
      bus.proc2Dmem_command = req_q.is_store ? BUS_STORE : BUS_LOAD;
    end

    if ((state_q == DMEM_DONE) && !bus.flush) begin
      bus.resp_valid    = 1'b1;
      bus.resp_is_store = req_q.is_store;
      bus.resp_err      = err_q;
      bus.resp_data     = data_q;
    end
  end

`ifdef DMEM_REQ_STATS_EN
  // Completion and stall counters, wrapping modulo 2^32
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_loads        <= '0;
      stat_stores       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (bus.resp_valid && req_q.is_store) begin
        stat_stores <= stat_stores + 32'd1;
      end
      if (bus.resp_valid && !req_q.is_store) begin
        stat_loads <= stat_loads + 32'd1;
      end
      if ((state_q == DMEM_ISSUE) || (state_q == DMEM_WAIT) || (state_q == DMEM_DRAIN)) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
